spi_master_multi: RTL and testbench

- Parametrised SPI master; next-generation replacement for the fixed 8-bit, single-slave master in the SPI verification environment.
- Generalises frame width, SCLK divider and slave-select count; supports all four CPOL/CPHA modes per transfer.
- Adds a start/busy/done handshake so the testcase or driver can chain transfers without polling internal shift registers.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_master_multi_clk_gen.sv | 47 ++++
 rtl/spi_master_multi.sv | 154 +++++++++++++++
 tb/tb_spi_master_multi.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the multi-slave SPI master: FSM state encoding and the
// packed {CPOL, CPHA} mode word.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_master_multi_clk_gen.sv
// SCLK generator: divider counter producing leading/trailing edge strobes
// while enabled, and the SCLK register parked at a given level otherwise.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic park,
  input  logic park_level,
  output logic lead_stb,
  output logic trail_stb,
  output logic sclk
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             trail_next;
  logic             tick;

  assign tick      = en && (div_cnt == DIV_LAST);
  assign lead_stb  = tick && !trail_next;
  assign trail_stb = tick && trail_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      trail_next <= 1'b0;
      sclk       <= 1'b0;
    end else if (!en) begin
      div_cnt    <= '0;
      trail_next <= 1'b0;
      if (park) sclk <= park_level;
    end else if (tick) begin
      div_cnt    <= '0;
      trail_next <= ~trail_next;
      sclk       <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master with per-transfer CPOL/CPHA, NUM_SS slave selects
// and a start/busy/done handshake. Define SPI_LSB_FIRST_EN to add lsb_first.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_SS  = 4,
  parameter int CLK_DIV = 4,
  localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS_n
);

  localparam int TMR_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  state_t            state, state_nxt;
  spi_mode_t         mode_q;
  logic [TMR_W-1:0]  tmr;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic              lsb_in, lsb_q;
  logic              lead_stb, trail_stb;
  logic              accept, last_trail, hold_end, timing;
  logic              shift_out, sample;
  logic              gen_en, gen_park, gen_level;

  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (int'(sel) == i) v[i] = 1'b0;
    end
    return v;
  endfunction

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] v, input logic b,
                                                 input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lsb_q <= 1'b0;
    else if (accept) lsb_q <= lsb_first;
  end
`else
  assign lsb_in = 1'b0;
  assign lsb_q  = 1'b0;
`endif

  assign gen_en    = (state == XFER);
  assign gen_park  = (state == IDLE) || (state == SETUP);
  assign gen_level = (state == IDLE) ? mode[1] : mode_q.cpol;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (gen_en),
    .park      (gen_park),
    .park_level(gen_level),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .sclk      (SCLK)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last_trail = 1'b0;
    hold_end   = 1'b0;
    timing     = (state == SETUP) || (state == HOLD);
    case (state)
      IDLE:  if (start) begin accept = 1'b1; state_nxt = SETUP; end
      SETUP: if (tmr == TMR_LAST) state_nxt = XFER;
      XFER:  if (trail_stb && bit_cnt == BIT_LAST) begin last_trail = 1'b1; state_nxt = HOLD; end
      HOLD:  if (tmr == TMR_LAST) begin hold_end = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
    // CPHA=0 pre-drives the first bit at accept, so the final trailing edge has nothing left to shift
    shift_out = mode_q.cpha ? lead_stb : (trail_stb && !last_trail);
    sample    = mode_q.cpha ? trail_stb : lead_stb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr     <= '0;
      bit_cnt <= '0;
      mode_q  <= MODE0;
      busy    <= 1'b0;
      done    <= 1'b0;
      SS_n    <= '1;
      MOSI    <= 1'b0;
      rx_data <= '0;
    end else begin
      done <= hold_end;
      if (timing && tmr != TMR_LAST) tmr <= tmr + 1'b1;
      else                           tmr <= '0;
      if (accept)         bit_cnt <= '0;
      else if (trail_stb) bit_cnt <= bit_cnt + 1'b1;
      if (accept) begin
        busy   <= 1'b1;
        SS_n   <= ss_decode(ss_sel);
        mode_q <= spi_mode_t'(mode);
        if (!mode[0]) MOSI <= first_bit(tx_data, lsb_in);
      end else if (shift_out) begin
        MOSI <= first_bit(tx_sr, lsb_q);
      end
      if (hold_end) begin
        busy    <= 1'b0;
        SS_n    <= '1;
        rx_data <= rx_sr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)         tx_sr <= mode[0] ? tx_data : shift_tx(tx_data, lsb_in);
    else if (shift_out) tx_sr <= shift_tx(tx_sr, lsb_q);
    if (sample) rx_sr <= shift_rx(rx_sr, MISO, lsb_q);
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi with an edge-driven SPI slave model.
module tb_spi_master_multi;

  localparam int DW   = 8;
  localparam int NSS  = 4;
  localparam int CDIV = 4;
  localparam int LAT  = CDIV * (2 * DW + 2) + 1;
  localparam int TMO  = 300;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [1:0]    ss_sel = 2'b00;
  logic [DW-1:0] tx_data = '0;
  logic          MISO = 1'b0;
`ifdef SPI_LSB_FIRST_EN
  logic          lsb_first = 1'b0;
`endif
  logic [DW-1:0] rx_data;
  logic          busy, done, SCLK, MOSI;
  logic [NSS-1:0] SS_n;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]  obs_got;
  int             obs_done_cyc, obs_rises;
  logic           obs_sclk_pre, obs_sclk_post, obs_first;
  logic [NSS-1:0] obs_ss, obs_ss_after;
  bit             obs_ss_glitch, obs_aborted;
  logic [NSS-1:0] obs_rst_ss;
  logic           obs_rst_sclk, obs_rst_busy, obs_rst_done;

  spi_master_multi #(.DATA_W(DW), .NUM_SS(NSS), .CLK_DIV(CDIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .ss_sel   (ss_sel),
    .tx_data  (tx_data),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .rx_data  (rx_data),
    .busy     (busy),
    .done     (done),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .SS_n     (SS_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic int bidx(input int k, input bit lsbf);
    return lsbf ? k : DW - 1 - k;
  endfunction

  function automatic logic [NSS-1:0] exp_ss(input int sel);
    logic [NSS-1:0] v;
    v = '1;
    v[sel] = 1'b0;
    return v;
  endfunction

  // Starts a transfer from a negedge and plays an SPI slave that follows the
  // SCLK edges as seen on the wire; returns at the negedge where done is seen.
  task automatic do_xfer(input logic [1:0] md, input int sel, input logic [DW-1:0] tx,
                         input logic [DW-1:0] ret, input bit lsbf, input int inject_at,
                         input int abort_at);
    logic [DW-1:0] got;
    int nl, nt, c;
    logic prev, cpol, cpha;
    cpol = md[1]; cpha = md[0];
    got = '0; nl = 0; nt = 0;
    obs_sclk_pre = SCLK; obs_first = 1'b0; obs_rises = 0;
    obs_ss_glitch = 0; obs_aborted = 0; obs_done_cyc = -1;
    mode = md; ss_sel = sel[1:0]; tx_data = tx; start = 1'b1;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = lsbf;
`endif
    @(negedge clk);
    start = 1'b0;
    c = 1;
    prev = SCLK;
    if (!cpha) MISO = ret[bidx(0, lsbf)];
    obs_ss = SS_n;
    while (c <= TMO) begin
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        obs_rst_ss = SS_n; obs_rst_sclk = SCLK; obs_rst_busy = busy; obs_rst_done = done;
        obs_aborted = 1;
        break;
      end
      if (c == inject_at) begin start = 1'b1; tx_data = 8'hFF; end
      else if (c == inject_at + 1) start = 1'b0;
      if (SCLK !== prev) begin
        if (prev == 1'b0 && SCLK == 1'b1) obs_rises++;
        if (prev == cpol) begin
          if (nl < DW) begin
            if (!cpha) begin
              got[bidx(nl, lsbf)] = MOSI;
              if (nl == 0) obs_first = MOSI;
            end else begin
              MISO = ret[bidx(nl, lsbf)];
            end
          end
          nl++;
        end else begin
          if (!cpha) begin
            nt++;
            if (nt < DW) MISO = ret[bidx(nt, lsbf)];
          end else begin
            if (nt < DW) begin
              got[bidx(nt, lsbf)] = MOSI;
              if (nt == 0) obs_first = MOSI;
            end
            nt++;
          end
        end
        prev = SCLK;
      end
      if (busy && SS_n !== obs_ss) obs_ss_glitch = 1;
      if (done) begin obs_done_cyc = c; break; end
      @(negedge clk);
      c++;
    end
    obs_got = got; obs_sclk_post = SCLK; obs_ss_after = SS_n;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (SS_n !== 4'b1111) begin errors++; $display("FAIL reset_ss: got %b required 1111", SS_n); end
    checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b required 0", SCLK); end
    checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b required 0", MOSI); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h required 00", rx_data); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || SS_n !== 4'b1111) begin
      errors++; $display("FAIL post_reset_idle: busy %b ss %b required 0 1111", busy, SS_n);
    end
  endtask

  task automatic test_mode0();
    mode = 2'b00;
    repeat (2) @(negedge clk);
    do_xfer(2'b00, 2, 8'hA5, 8'h3C, 0, 0, 0);
    checks++; if (obs_got !== 8'hA5) begin errors++; $display("FAIL m0_slave_rx: got %h required a5", obs_got); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL m0_rx_data: got %h required 3c", rx_data); end
    checks++; if (obs_ss !== 4'b1011) begin errors++; $display("FAIL m0_ss: got %b required 1011", obs_ss); end
    checks++; if (obs_ss_glitch) begin errors++; $display("FAIL m0_ss_stable: got glitch required stable"); end
    checks++; if (obs_done_cyc != LAT) begin errors++; $display("FAIL m0_latency: got %0d required %0d", obs_done_cyc, LAT); end
    checks++; if (obs_rises != DW) begin errors++; $display("FAIL m0_rises: got %0d required %0d", obs_rises, DW); end
    checks++; if (obs_ss_after !== 4'b1111 || busy !== 1'b0) begin
      errors++; $display("FAIL m0_end: ss %b busy %b required 1111 0", obs_ss_after, busy);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL m0_done_pulse: got %b required 0", done); end
  endtask

  task automatic test_modes();
    for (int m = 1; m < 4; m++) begin
      mode = m[1:0];
      repeat (3) @(negedge clk);
      do_xfer(m[1:0], m, 8'h5A, 8'hC3, 0, 0, 0);
      checks++; if (obs_sclk_pre !== m[1]) begin errors++; $display("FAIL mode%0d_sclk_pre: got %b required %b", m, obs_sclk_pre, m[1]); end
      checks++; if (obs_got !== 8'h5A) begin errors++; $display("FAIL mode%0d_slave_rx: got %h required 5a", m, obs_got); end
      checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL mode%0d_rx_data: got %h required c3", m, rx_data); end
      checks++; if (obs_sclk_post !== m[1]) begin errors++; $display("FAIL mode%0d_sclk_post: got %b required %b", m, obs_sclk_post, m[1]); end
      checks++; if (obs_ss_after !== 4'b1111) begin errors++; $display("FAIL mode%0d_ss_after: got %b required 1111", m, obs_ss_after); end
      checks++; if (obs_done_cyc != LAT) begin errors++; $display("FAIL mode%0d_latency: got %0d required %0d", m, obs_done_cyc, LAT); end
    end
  endtask

  task automatic test_ignore_start();
    logic [DW-1:0] tx, ret;
    int dones, busy_seen;
    tx = 8'($urandom_range(0, 254)); ret = 8'($urandom);
    mode = 2'b00;
    repeat (2) @(negedge clk);
    do_xfer(2'b00, 1, tx, ret, 0, 10, 0);
    checks++; if (obs_got !== tx) begin errors++; $display("FAIL ign_slave_rx: got %h required %h", obs_got, tx); end
    checks++; if (rx_data !== ret) begin errors++; $display("FAIL ign_rx_data: got %h required %h", rx_data, ret); end
    checks++; if (obs_done_cyc != LAT) begin errors++; $display("FAIL ign_latency: got %0d required %0d", obs_done_cyc, LAT); end
    dones = 0; busy_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busy_seen++;
    end
    checks++; if (dones != 0 || busy_seen != 0) begin
      errors++; $display("FAIL ign_single_done: extra dones %0d busy cycles %0d required 0 0", dones, busy_seen);
    end
  endtask

  task automatic test_back_to_back();
    mode = 2'b00;
    repeat (2) @(negedge clk);
    do_xfer(2'b00, 0, 8'h01, 8'h69, 0, 0, 0);
    checks++; if (obs_got !== 8'h01) begin errors++; $display("FAIL b2b1_slave_rx: got %h required 01", obs_got); end
    checks++; if (rx_data !== 8'h69) begin errors++; $display("FAIL b2b1_rx_data: got %h required 69", rx_data); end
    checks++; if (obs_ss_after !== 4'b1111) begin errors++; $display("FAIL b2b_ss_gap: got %b required 1111", obs_ss_after); end
    do_xfer(2'b00, 3, 8'h80, 8'hE7, 0, 0, 0);
    checks++; if (obs_got !== 8'h80) begin errors++; $display("FAIL b2b2_slave_rx: got %h required 80", obs_got); end
    checks++; if (rx_data !== 8'hE7) begin errors++; $display("FAIL b2b2_rx_data: got %h required e7", rx_data); end
    checks++; if (obs_done_cyc != LAT) begin errors++; $display("FAIL b2b2_latency: got %0d required %0d", obs_done_cyc, LAT); end
    checks++; if (obs_ss !== 4'b0111) begin errors++; $display("FAIL b2b2_ss: got %b required 0111", obs_ss); end
  endtask

  task automatic test_abort();
    logic [DW-1:0] tx, ret;
    int dones;
    tx = 8'($urandom); ret = 8'($urandom);
    mode = 2'b00;
    repeat (2) @(negedge clk);
    do_xfer(2'b00, 2, tx, ret, 0, 0, 30);
    checks++; if (!obs_aborted) begin errors++; $display("FAIL abort_reached: got done at %0d required reset at 30", obs_done_cyc); end
    checks++; if (obs_rst_ss !== 4'b1111) begin errors++; $display("FAIL abort_ss: got %b required 1111", obs_rst_ss); end
    checks++; if (obs_rst_sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b required 0", obs_rst_sclk); end
    checks++; if (obs_rst_busy !== 1'b0 || obs_rst_done !== 1'b0) begin
      errors++; $display("FAIL abort_busy_done: got %b %b required 0 0", obs_rst_busy, obs_rst_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d dones required 0", dones); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL abort_rx_cleared: got %h required 00", rx_data); end
    tx = 8'($urandom); ret = 8'($urandom);
    do_xfer(2'b00, 1, tx, ret, 0, 0, 0);
    checks++; if (obs_got !== tx || rx_data !== ret) begin
      errors++; $display("FAIL abort_recover: got %h/%h required %h/%h", obs_got, rx_data, tx, ret);
    end
    checks++; if (obs_done_cyc != LAT) begin errors++; $display("FAIL abort_recover_latency: got %0d required %0d", obs_done_cyc, LAT); end
  endtask

  task automatic test_random();
    logic [1:0] md;
    logic [DW-1:0] tx, ret;
    int sel;
    for (int n = 0; n < 10; n++) begin
      md = 2'($urandom); sel = $urandom_range(0, NSS - 1);
      tx = 8'($urandom); ret = 8'($urandom);
      mode = md;
      repeat (2) @(negedge clk);
      do_xfer(md, sel, tx, ret, 0, 0, 0);
      checks++; if (obs_got !== tx) begin errors++; $display("FAIL rnd%0d_slave_rx: got %h required %h", n, obs_got, tx); end
      checks++; if (rx_data !== ret) begin errors++; $display("FAIL rnd%0d_rx_data: got %h required %h", n, rx_data, ret); end
      checks++; if (obs_ss !== exp_ss(sel)) begin errors++; $display("FAIL rnd%0d_ss: got %b required %b", n, obs_ss, exp_ss(sel)); end
      checks++; if (obs_done_cyc != LAT || obs_sclk_post !== md[1]) begin
        errors++; $display("FAIL rnd%0d_timing: got cyc %0d sclk %b required %0d %b", n, obs_done_cyc, obs_sclk_post, LAT, md[1]);
      end
    end
  endtask

`ifdef SPI_LSB_FIRST_EN
  task automatic test_lsb_first();
    mode = 2'b00;
    repeat (2) @(negedge clk);
    do_xfer(2'b00, 1, 8'h01, 8'h80, 1, 0, 0);
    checks++; if (obs_first !== 1'b1) begin errors++; $display("FAIL lsb_first_bit: got %b required 1", obs_first); end
    checks++; if (obs_got !== 8'h01) begin errors++; $display("FAIL lsb_slave_rx: got %h required 01", obs_got); end
    checks++; if (rx_data !== 8'h80) begin errors++; $display("FAIL lsb_rx_data: got %h required 80", rx_data); end
    @(negedge clk);
    do_xfer(2'b11, 2, 8'h01, 8'h80, 1, 0, 0);
    checks++; if (obs_got !== 8'h01 || rx_data !== 8'h80) begin
      errors++; $display("FAIL lsb_mode3: got %h/%h required 01/80", obs_got, rx_data);
    end
    lsb_first = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_random();
`ifdef SPI_LSB_FIRST_EN
    test_lsb_first();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
